cpu_run_controller: RTL and testbench

- Sequences the riscv32 core on the board by gating its clock enable, holding its reset, and counting executed cycles.
- Replaces the free-running divided clock. The core runs on the board clock and advances only when cpu_en is high.
- Board buttons select continuous run, pause, single-step or reset. The controller halts the core on a done indication or on a cycle budget, and exports status for the LEDs.

---
 rtl/cpu_run_controller_pkg.sv | 18 +
 rtl/cpu_run_controller_if.sv | 27 ++
 rtl/cpu_run_controller_btn_debounce.sv | 57 +++++
 rtl/cpu_run_controller.sv | 139 +++++++++++++
 tb/tb_cpu_run_controller.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_run_controller_pkg.sv
// Shared types and default constants for the CPU run controller.
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_HOLD = 3'd0,
        IDLE       = 3'd1,
        RUN        = 3'd2,
        STEP       = 3'd3,
        HALT       = 3'd4
    } ctrl_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 1000000;
    localparam int DEF_TICK_DIV        = 4;
    localparam int DEF_RESET_CYCLES    = 4;
    localparam int DEF_CYCLE_W         = 32;
    localparam int DEF_MAX_CYCLES      = 50000;

endpackage

// File: rtl/cpu_run_controller_if.sv
// Board-facing signal bundle of the run controller: buttons, core handshake and status.
interface cpu_run_controller_if #(
    parameter int CYCLE_W = 32
);
    logic               btn_run;
    logic               btn_step;
    logic               btn_rst;
    logic               cpu_done;
    logic               cpu_en;
    logic               cpu_reset;
    logic [2:0]         state;
    logic [CYCLE_W-1:0] cycle_count;
    logic               timeout;
    logic               done_latched;
    logic [2:0]         btn_level;
    logic [3:0]         led;

    modport master (
        output btn_run, btn_step, btn_rst, cpu_done,
        input  cpu_en, cpu_reset, state, cycle_count, timeout, done_latched, btn_level, led
    );

    modport slave (
        input  btn_run, btn_step, btn_rst, cpu_done,
        output cpu_en, cpu_reset, state, cycle_count, timeout, done_latched, btn_level, led
    );
endinterface

// File: rtl/cpu_run_controller_btn_debounce.sv
// Two-flop synchronizer plus stability counter; emits a one-cycle pulse on each accepted press.
module btn_debounce
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = 1'b0;
        cnt_d   = '0;
        // The counter only runs while the synchronized input disagrees with the accepted level.
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_press = press_q;
endmodule

// File: rtl/cpu_run_controller.sv
// Run/pause/step/reset sequencer for the core: gates cpu_en, holds cpu_reset, counts executed cycles.
module cpu_run_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TICK_DIV        = DEF_TICK_DIV,
    parameter int RESET_CYCLES    = DEF_RESET_CYCLES,
    parameter int CYCLE_W         = DEF_CYCLE_W,
    parameter int MAX_CYCLES      = DEF_MAX_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset,
    cpu_run_controller_if.slave  bus
);
    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] BUDGET     = CYCLE_W'(MAX_CYCLES);

    function automatic logic [CYCLE_W-1:0] sat_inc(input logic [CYCLE_W-1:0] v);
        return (v == '1) ? v : v + CYCLE_W'(1);
    endfunction

    logic run_press, step_press, rst_press;
    logic run_level, step_level, rst_level;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_run (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_run),
        .btn_level(run_level), .btn_press(run_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_step (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_step),
        .btn_level(step_level), .btn_press(step_press)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_rst (
        .clk(clk), .reset(reset), .btn_raw(bus.btn_rst),
        .btn_level(rst_level), .btn_press(rst_press)
    );

    ctrl_state_t        state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               cpu_en_q, cpu_en_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic [CYCLE_W-1:0] count_q, count_d;
    logic               timeout_q, timeout_d;
    logic               done_q, done_d;

    logic [CYCLE_W-1:0] count_inc;
    logic               hit_done, hit_budget;
    logic               step_act, run_act;

    always_comb begin
        state_d     = state_q;
        hold_d      = '0;
        presc_d     = '0;
        count_d     = count_q;
        timeout_d   = timeout_q;
        done_d      = done_q;
        count_inc   = sat_inc(count_q);
        hit_done    = cpu_en_q & bus.cpu_done;
        hit_budget  = cpu_en_q & (count_inc == BUDGET);
        // Lower-priority presses are dropped whenever a higher one lands in the same cycle.
        step_act    = step_press & ~rst_press;
        run_act     = run_press & ~step_press & ~rst_press;

        if (cpu_en_q) begin
            count_d = count_inc;
            if (hit_done)   done_d    = 1'b1;
            if (hit_budget) timeout_d = 1'b1;
        end

        if (rst_press) begin
            state_d = RESET_HOLD;
        end else if (hit_done || hit_budget) begin
            state_d = HALT;
        end else begin
            case (state_q)
                RESET_HOLD: begin
                    if (hold_q == HOLD_LAST) state_d = IDLE;
                    else                     hold_d  = hold_q + HOLD_W'(1);
                end
                IDLE: begin
                    if (step_act)     state_d = STEP;
                    else if (run_act) state_d = RUN;
                end
                RUN: begin
                    if (run_act) state_d = IDLE;
                    else         presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + PRESC_W'(1);
                end
                STEP:    state_d = IDLE;
                HALT:    state_d = HALT;
                default: state_d = RESET_HOLD;
            endcase
        end

        if (state_d == RESET_HOLD) begin
            count_d   = '0;
            timeout_d = 1'b0;
            done_d    = 1'b0;
        end

        // Registered decode of the next state keeps cpu_en glitch-free at the core.
        cpu_en_d    = ((state_d == RUN) && (presc_d == PRESC_LAST)) || (state_d == STEP);
        cpu_reset_d = (state_d == RESET_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_HOLD;
            hold_q      <= '0;
            presc_q     <= '0;
            cpu_en_q    <= 1'b0;
            cpu_reset_q <= 1'b1;
            count_q     <= '0;
            timeout_q   <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            presc_q     <= presc_d;
            cpu_en_q    <= cpu_en_d;
            cpu_reset_q <= cpu_reset_d;
            count_q     <= count_d;
            timeout_q   <= timeout_d;
            done_q      <= done_d;
        end
    end

    assign bus.cpu_en       = cpu_en_q;
    assign bus.cpu_reset    = cpu_reset_q;
    assign bus.state        = state_q;
    assign bus.cycle_count  = count_q;
    assign bus.timeout      = timeout_q;
    assign bus.done_latched = done_q;
    assign bus.btn_level    = {rst_level, step_level, run_level};
    assign bus.led          = {timeout_q, state_q};
endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed sequences, a vector table and a random run against a reference model.
`timescale 1ns/1ps
module tb_cpu_run_controller;
    import cpu_ctrl_pkg::*;

    localparam int D    = 4;
    localparam int TD   = 4;
    localparam int RC   = 4;
    localparam int CW   = 32;
    localparam int MAXC = 20;
    localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_run_controller_if #(.CYCLE_W(CW)) bus_a ();
    cpu_run_controller_if #(.CYCLE_W(CW)) bus_b ();

    cpu_run_controller #(
        .DEBOUNCE_CYCLES(D), .TICK_DIV(TD), .RESET_CYCLES(RC), .CYCLE_W(CW), .MAX_CYCLES(MAXC)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus_a)
    );

    cpu_run_controller #(
        .DEBOUNCE_CYCLES(D), .TICK_DIV(1), .RESET_CYCLES(RC), .CYCLE_W(CW), .MAX_CYCLES(50000)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    assign bus_b.btn_run  = bus_a.btn_run;
    assign bus_b.btn_step = bus_a.btn_step;
    assign bus_b.btn_rst  = bus_a.btn_rst;
    assign bus_b.cpu_done = 1'b0;

    int total = 0;
    int bad   = 0;
    int hl_run = 0, hl_step = 0, hl_rst = 0;
    int en_seen = 0;

    // Reference model state
    ctrl_state_t m_st;
    int          m_hold;
    int          m_age;
    bit          m_en, m_crst, m_to, m_dl;
    longint      m_cnt;
    bit [2:0]    m_press;
    bit [2:0]    m_lvl;
    bit          hist[3][$];

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = RESET_HOLD; m_hold = 0; m_age = 0;
        m_en = 0; m_crst = 1; m_to = 0; m_dl = 0; m_cnt = 0;
        m_press = '0; m_lvl = '0;
        for (int b = 0; b < 3; b++) begin
            hist[b].delete();
            repeat (D + 2) hist[b].push_back(1'b0);
        end
    endtask

    // raw bit order: 0=run, 1=step, 2=rst
    task automatic model_step(input bit [2:0] raw, input bit done, input bit rst_in);
        ctrl_state_t nst;
        longint      inc;
        bit          flip;
        int          sz;
        if (rst_in) begin
            model_reset();
            return;
        end
        nst = m_st;
        inc = (m_en && m_cnt < CNT_MAX) ? m_cnt + 1 : m_cnt;
        if (m_press[2]) begin
            nst = RESET_HOLD;
            m_hold = 0;
        end else if (m_st == RESET_HOLD) begin
            if (m_hold == RC - 1) begin nst = IDLE; m_hold = 0; end
            else m_hold++;
        end else begin
            m_cnt = inc;
            if (m_en && done) m_dl = 1;
            if (m_en && inc == MAXC) m_to = 1;
            if (m_en && (done || inc == MAXC)) nst = HALT;
            else begin
                case (m_st)
                    IDLE: if (m_press[1]) nst = STEP; else if (m_press[0]) nst = RUN;
                    RUN:  if (m_press[0] && !m_press[1]) nst = IDLE;
                    STEP: nst = IDLE;
                    default: ;
                endcase
            end
        end
        if (nst == RUN) m_age++; else m_age = 0;
        if (nst == RESET_HOLD) begin m_cnt = 0; m_to = 0; m_dl = 0; end
        m_st   = nst;
        m_en   = ((nst == RUN) && (m_age % TD == 0)) || (nst == STEP);
        m_crst = (nst == RESET_HOLD);
        // A level is accepted once the last D synchronized samples all disagree with it.
        for (int b = 0; b < 3; b++) begin
            sz = hist[b].size();
            flip = 1;
            for (int i = 1; i <= D; i++)
                if (hist[b][sz - 1 - i] == m_lvl[b]) flip = 0;
            m_press[b] = flip && !m_lvl[b];
            if (flip) m_lvl[b] = !m_lvl[b];
            hist[b].push_back(raw[b]);
            if (hist[b].size() > D + 4) void'(hist[b].pop_front());
        end
    endtask

    task automatic tick();
        bit [2:0] raw;
        bit dn, rs;
        raw = {bus_a.btn_rst, bus_a.btn_step, bus_a.btn_run};
        dn  = bus_a.cpu_done;
        rs  = reset;
        @(posedge clk);
        model_step(raw, dn, rs);
        #1;
        cmp("model", {bus_a.state, bus_a.cpu_en, bus_a.cpu_reset, bus_a.timeout, bus_a.done_latched, bus_a.cycle_count},
            {3'(m_st), m_en, m_crst, m_to, m_dl, m_cnt[31:0]});
        if (bus_a.cpu_en) en_seen++;
        if (hl_run  > 0) begin hl_run--;  if (hl_run  == 0) bus_a.btn_run  = 1'b0; end
        if (hl_step > 0) begin hl_step--; if (hl_step == 0) bus_a.btn_step = 1'b0; end
        if (hl_rst  > 0) begin hl_rst--;  if (hl_rst  == 0) bus_a.btn_rst  = 1'b0; end
    endtask

    typedef struct {
        int          act;   // 0 wait, 1 run press, 2 step press, 3 rst press
        int          n;
        ctrl_state_t st;
        int          cnt;
        bit          to;
        bit          dl;
        int          en;    // cpu_en pulses expected during the vector, -1 = unchecked
    } vec_t;

    vec_t tbl[8];
    int glitch_press, pulses, e0;
    bit found;

    initial begin
        tbl = '{
            '{0, 45, HALT,       20, 1'b1, 1'b0, -1},
            '{1, 20, HALT,       20, 1'b1, 1'b0,  0},
            '{2, 20, HALT,       20, 1'b1, 1'b0,  0},
            '{3,  8, RESET_HOLD,  0, 1'b0, 1'b0,  0},
            '{0, 12, IDLE,        0, 1'b0, 1'b0,  0},
            '{2, 20, IDLE,        1, 1'b0, 1'b0,  1},
            '{2, 20, IDLE,        2, 1'b0, 1'b0,  1},
            '{2, 20, IDLE,        3, 1'b0, 1'b0,  1}
        };
        bus_a.btn_run = 1'b0; bus_a.btn_step = 1'b0; bus_a.btn_rst = 1'b0; bus_a.cpu_done = 1'b0;
        reset = 1'b1;
        model_reset();

        // Reset values, then release and hold window
        repeat (3) tick();
        cmp("rst_state", bus_a.state, RESET_HOLD);
        cmp("rst_cpu_reset", bus_a.cpu_reset, 1);
        cmp("rst_cpu_en", bus_a.cpu_en, 0);
        cmp("rst_count", bus_a.cycle_count, 0);
        cmp("rst_flags", {bus_a.timeout, bus_a.done_latched}, 0);
        reset = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            cmp("hold_cpu_reset", bus_a.cpu_reset, (k < 4) ? 1 : 0);
            cmp("hold_state", bus_a.state, (k < 4) ? RESET_HOLD : IDLE);
        end
        cmp("idle_count", bus_a.cycle_count, 0);

        // 3-clock glitch must not be accepted
        glitch_press = 0;
        bus_a.btn_run = 1'b1; hl_run = 3;
        repeat (12) begin
            tick();
            if (dut.u_db_run.btn_press) glitch_press++;
        end
        cmp("glitch_press", glitch_press, 0);
        cmp("glitch_state", bus_a.state, IDLE);

        // Clean press: pulse 6 clocks after the raw edge, RUN the clock after
        bus_a.btn_run = 1'b1; hl_run = 10;
        for (int k = 1; k <= 7; k++) begin
            tick();
            cmp("press_pulse", dut.u_db_run.btn_press, (k == 6) ? 1 : 0);
            if (k < 7) cmp("pre_run_state", bus_a.state, IDLE);
        end
        cmp("run_entry", bus_a.state, RUN);
        cmp("b_run_entry", bus_b.state, RUN);
        for (int k = 1; k <= 40; k++) begin
            if (k > 1) tick();
            cmp("run_en", bus_a.cpu_en, (k % 4 == 0) ? 1 : 0);
            cmp("b_run_en", bus_b.cpu_en, 1);
        end
        tick();
        cmp("run_count", bus_a.cycle_count, 10);
        cmp("b_run_count", bus_b.cycle_count, 40);

        // Budget, halt immunity, reset recovery, single steps
        for (int v = 0; v < 8; v++) begin
            e0 = en_seen;
            case (tbl[v].act)
                1: begin bus_a.btn_run  = 1'b1; hl_run  = 10; end
                2: begin bus_a.btn_step = 1'b1; hl_step = 10; end
                3: begin bus_a.btn_rst  = 1'b1; hl_rst  = 10; end
                default: ;
            endcase
            repeat (tbl[v].n) tick();
            cmp($sformatf("vec%0d_state", v), bus_a.state, tbl[v].st);
            cmp($sformatf("vec%0d_count", v), bus_a.cycle_count, tbl[v].cnt);
            cmp($sformatf("vec%0d_flags", v), {bus_a.timeout, bus_a.done_latched}, {tbl[v].to, tbl[v].dl});
            if (tbl[v].en >= 0) cmp($sformatf("vec%0d_en_pulses", v), en_seen - e0, tbl[v].en);
        end

        // cpu_done on the 7th pulse of a run, then rst and run pressed together
        bus_a.btn_run = 1'b1; hl_run = 10;
        pulses = 0; found = 0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (bus_a.cpu_en) begin
                pulses++;
                if (pulses == 7) found = 1;
            end
        end
        cmp("wait_7th_pulse", found, 1);
        bus_a.cpu_done = 1'b1;
        tick();
        bus_a.cpu_done = 1'b0;
        cmp("done_state", bus_a.state, HALT);
        cmp("done_latched", bus_a.done_latched, 1);
        cmp("done_timeout", bus_a.timeout, 0);
        cmp("done_count", bus_a.cycle_count, 10);
        repeat (3) tick();
        cmp("done_frozen", bus_a.cycle_count, 10);
        bus_a.btn_rst = 1'b1; hl_rst = 10;
        bus_a.btn_run = 1'b1; hl_run = 10;
        repeat (7) tick();
        cmp("both_state", bus_a.state, RESET_HOLD);
        cmp("both_cleared", {bus_a.done_latched, bus_a.cycle_count}, 0);
        repeat (12) tick();
        cmp("both_idle", bus_a.state, IDLE);

        // Random buttons, done and occasional reset against the model
        for (int c = 0; c < 3000; c++) begin
            if (hl_run == 0)  begin bus_a.btn_run  = 1'($urandom_range(0, 1)); hl_run  = $urandom_range(1, 14); end
            if (hl_step == 0) begin bus_a.btn_step = ($urandom_range(0, 2) == 0); hl_step = $urandom_range(1, 14); end
            if (hl_rst == 0)  begin bus_a.btn_rst  = ($urandom_range(0, 7) == 0); hl_rst  = $urandom_range(1, 14); end
            bus_a.cpu_done = ($urandom_range(0, 9) == 0);
            reset = ($urandom_range(0, 499) == 0);
            tick();
        end
        reset = 1'b0;
        bus_a.cpu_done = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
